// File: rtl/gt_sweep_checker_pkg.sv
// Shared definitions for the comparator self-test stage.
//   - state_e     : sweep controller states
//   - DEF_WIDTH   : default operand width of the comparator under test
//   - NUM_PAIRS   : number of (A,B) pairs swept at the default width
//   - expected_gt : golden unsigned greater-than used to judge each sample
package gt_sweep_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int MAX_WIDTH = 8;
  localparam int NUM_PAIRS = 2 ** (2 * DEF_WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Operands are zero-extended to MAX_WIDTH by the caller, so this stays an
  // unsigned compare for any supported width.
  function automatic logic expected_gt(input logic [MAX_WIDTH-1:0] a,
                                       input logic [MAX_WIDTH-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/gt_sweep_checker_if.sv
// Operand/result bus between the self-test stage and the comparator.
//   A_out, B_out : operands driven by the checker (registered)
//   GT_in        : comparator result returned to the checker
// master = checker side, slave = comparator side.
interface gt_sweep_checker_if
  import gt_sweep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] A_out;
  logic [WIDTH-1:0] B_out;
  logic             GT_in;

  modport master (output A_out, output B_out, input GT_in);
  modport slave  (input A_out, input B_out, output GT_in);

endinterface

// File: rtl/gt_sweep_checker_operand_counter.sv
// Pair counter for the operand sweep.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous return to pair 0 (wins over enable)
//   enable   : advance to the next pair
//   count    : current pair; upper half is A, lower half is B, so B is the
//              inner loop and A steps when B wraps
//   last     : high while count holds the final pair
module operand_counter #(
  parameter int              BITS = 8,
  parameter logic [BITS-1:0] LAST = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  output logic [BITS-1:0] count,
  output logic            last
);

  logic [BITS-1:0] cnt_q;
  logic [BITS-1:0] cnt_d;

  // Next pair: clear has priority so a new sweep always starts at (0,0).
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + BITS'(1);
    end
  end

  // Pair register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign last  = (cnt_q == LAST);

endmodule

// File: rtl/gt_sweep_checker.sv
// Built-in self-test for the greater-than comparator. After a start pulse it
// sweeps every (A,B) pair (A outer, B inner), samples GT_in once per pair,
// and checks it against the unsigned A>B.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : one-cycle pulse, accepted in IDLE or DONE only
//   cmp           : operand/result bus to the comparator (master side)
//   busy          : sweep in progress
//   done          : sweep finished; results held until next start/reset
//   pass          : done and no mismatches
//   gt_count      : number of samples with GT_in==1
//   err_count     : number of samples with GT_in != (A>B)
//   first_err_A/B : first mismatching pair, 0 if none
module gt_sweep_checker
  import gt_sweep_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  gt_sweep_checker_if.master   cmp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     gt_count,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH-1:0]     first_err_A,
  output logic [WIDTH-1:0]     first_err_B
);

  localparam int CW          = 2 * WIDTH + 1;
  localparam int SCW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam int PAIRS       = (WIDTH == DEF_WIDTH) ? NUM_PAIRS : 2 ** (2 * WIDTH);
  localparam logic [2*WIDTH-1:0] LAST_PAIR = (2 * WIDTH)'(PAIRS - 1);

  state_e           state_q, state_d;
  logic [SCW-1:0]   settle_q, settle_d;
  logic [CW-1:0]    gt_count_q, gt_count_d;
  logic [CW-1:0]    err_count_q, err_count_d;
  logic [WIDTH-1:0] first_a_q, first_a_d;
  logic [WIDTH-1:0] first_b_q, first_b_d;
  logic             err_seen_q, err_seen_d;

  logic               pair_clear;
  logic               pair_en;
  logic               pair_last;
  logic [2*WIDTH-1:0] pair;
  logic               exp_gt;

  operand_counter #(
    .BITS (2 * WIDTH),
    .LAST (LAST_PAIR)
  ) u_pairs (
    .clk    (clk),
    .rst    (rst),
    .clear  (pair_clear),
    .enable (pair_en),
    .count  (pair),
    .last   (pair_last)
  );

  assign cmp.A_out = pair[2*WIDTH-1:WIDTH];
  assign cmp.B_out = pair[WIDTH-1:0];

  // Sweep controller. Each pair spends one DRIVE cycle, SETTLE_CYCLES settle
  // cycles and one SAMPLE cycle. GT_in only influences state in SAMPLE. On the
  // final pair the counter is not advanced, so the operands stay at max.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    gt_count_d  = gt_count_q;
    err_count_d = err_count_q;
    first_a_d   = first_a_q;
    first_b_d   = first_b_q;
    err_seen_d  = err_seen_q;
    pair_clear  = 1'b0;
    pair_en     = 1'b0;
    exp_gt      = expected_gt(MAX_WIDTH'(cmp.A_out), MAX_WIDTH'(cmp.B_out));
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          gt_count_d  = '0;
          err_count_d = '0;
          first_a_d   = '0;
          first_b_d   = '0;
          err_seen_d  = 1'b0;
          pair_clear  = 1'b1;
          state_d     = DRIVE;
        end
      end
      DRIVE: begin
        if (SETTLE_CYCLES > 0) begin
          settle_d = SCW'(SETTLE_LOAD);
          state_d  = SETTLE;
        end else begin
          state_d = SAMPLE;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q - SCW'(1);
        end
      end
      SAMPLE: begin
        gt_count_d = gt_count_q + CW'(cmp.GT_in);
        if (cmp.GT_in != exp_gt) begin
          err_count_d = err_count_q + CW'(1);
          if (!err_seen_q) begin
            first_a_d  = cmp.A_out;
            first_b_d  = cmp.B_out;
            err_seen_d = 1'b1;
          end
        end
        if (pair_last) begin
          state_d = DONE;
        end else begin
          pair_en = 1'b1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller, settle counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      gt_count_q  <= '0;
      err_count_q <= '0;
      first_a_q   <= '0;
      first_b_q   <= '0;
      err_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      gt_count_q  <= gt_count_d;
      err_count_q <= err_count_d;
      first_a_q   <= first_a_d;
      first_b_q   <= first_b_d;
      err_seen_q  <= err_seen_d;
    end
  end

  assign busy        = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == SAMPLE);
  assign done        = (state_q == DONE);
  assign pass        = done && (err_count_q == '0);
  assign gt_count    = gt_count_q;
  assign err_count   = err_count_q;
  assign first_err_A = first_a_q;
  assign first_err_B = first_b_q;

endmodule

// File: tb/tb_gt_sweep_checker.sv
// Self-checking bench for gt_sweep_checker. Two instances are exercised: one
// with one settle cycle and one with none. The comparator is replaced by a
// lookup table so stuck-at and randomly corrupted comparators can be modelled;
// expected results come from walking that table in plain nested loops.
module tb_gt_sweep_checker;
  import gt_sweep_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  logic start1;
  logic start0;

  logic         busy1, done1, pass1, busy0, done0, pass0;
  logic [2*W:0] gtc1, errc1, gtc0, errc0;
  logic [W-1:0] fea1, feb1, fea0, feb0;

  gt_sweep_checker_if #(.WIDTH(W)) cmp1 ();
  gt_sweep_checker_if #(.WIDTH(W)) cmp0 ();

  bit gt_table [NUM_PAIRS];

  assign cmp1.GT_in = gt_table[{cmp1.A_out, cmp1.B_out}];
  assign cmp0.GT_in = gt_table[{cmp0.A_out, cmp0.B_out}];

  gt_sweep_checker #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cmp(cmp1),
    .busy(busy1), .done(done1), .pass(pass1),
    .gt_count(gtc1), .err_count(errc1),
    .first_err_A(fea1), .first_err_B(feb1)
  );

  gt_sweep_checker #(.WIDTH(W), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .cmp(cmp0),
    .busy(busy0), .done(done0), .pass(pass0),
    .gt_count(gtc0), .err_count(errc0),
    .first_err_A(fea0), .first_err_B(feb0)
  );

  always #5 clk = ~clk;

  // Selected-instance view so one set of tasks serves both DUTs.
  bit sel0;
  logic [31:0] m_busy, m_done, m_pass, m_gtc, m_errc, m_fea, m_feb, m_a, m_b;
  assign m_busy = sel0 ? 32'(busy0) : 32'(busy1);
  assign m_done = sel0 ? 32'(done0) : 32'(done1);
  assign m_pass = sel0 ? 32'(pass0) : 32'(pass1);
  assign m_gtc  = sel0 ? 32'(gtc0)  : 32'(gtc1);
  assign m_errc = sel0 ? 32'(errc0) : 32'(errc1);
  assign m_fea  = sel0 ? 32'(fea0)  : 32'(fea1);
  assign m_feb  = sel0 ? 32'(feb0)  : 32'(feb1);
  assign m_a    = sel0 ? 32'(cmp0.A_out) : 32'(cmp1.A_out);
  assign m_b    = sel0 ? 32'(cmp0.B_out) : 32'(cmp1.B_out);

  int checks = 0;
  int failures = 0;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Loads the comparator stand-in: 0 ideal, 1 stuck-at-0, 2 stuck-at-1,
  // 3 ideal with sparse random corruption, 4 fully random.
  task automatic applyStimulus(input int mode);
    for (int i = 0; i < NUM_PAIRS; i++) begin
      bit ideal;
      ideal = (i / (1 << W)) > (i % (1 << W));
      case (mode)
        1:       gt_table[i] = 1'b0;
        2:       gt_table[i] = 1'b1;
        3:       gt_table[i] = ideal ^ ($urandom_range(0, 15) == 0);
        4:       gt_table[i] = 1'($urandom_range(0, 1));
        default: gt_table[i] = ideal;
      endcase
    end
  endtask

  // Reference: what a sweep over the current table must report.
  task automatic computeModel(output int eg, output int ee, output int efa, output int efb);
    eg = 0; ee = 0; efa = 0; efb = 0;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        bit g;
        g = gt_table[a * (1 << W) + b];
        if (g) eg++;
        if (g != (a > b)) begin
          if (ee == 0) begin efa = a; efb = b; end
          ee++;
        end
      end
    end
  endtask

  task automatic setStart(input logic v);
    if (sel0) start0 = v; else start1 = v;
  endtask

  // Pulses start, then counts cycles until done; restartAt>0 re-pulses start
  // mid-sweep, which must not disturb anything.
  task automatic runSweep(input string tag, input int expCycles, input int restartAt);
    int cycles;
    bit finished;
    cycles = 0;
    finished = 1'b0;
    @(posedge clk); #1 setStart(1'b1);
    @(posedge clk); #1 setStart(1'b0);
    checkOutput({tag, ":busy_start"}, m_busy, 1);
    checkOutput({tag, ":done_start"}, m_done, 0);
    while (!finished && cycles < expCycles + 50) begin
      @(posedge clk); #1;
      cycles++;
      setStart(cycles == restartAt);
      if (m_done == 1) finished = 1'b1;
    end
    setStart(1'b0);
    checkOutput({tag, ":cycles"}, cycles, expCycles);
  endtask

  task automatic checkResults(input string tag);
    int eg, ee, efa, efb;
    computeModel(eg, ee, efa, efb);
    checkOutput({tag, ":gt_count"}, m_gtc, eg);
    checkOutput({tag, ":err_count"}, m_errc, ee);
    checkOutput({tag, ":pass"}, m_pass, 32'(ee == 0));
    checkOutput({tag, ":first_A"}, m_fea, efa);
    checkOutput({tag, ":first_B"}, m_feb, efb);
    checkOutput({tag, ":busy"}, m_busy, 0);
    checkOutput({tag, ":A_max"}, m_a, (1 << W) - 1);
    checkOutput({tag, ":B_max"}, m_b, (1 << W) - 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ":A"}, m_a, 0);
    checkOutput({tag, ":B"}, m_b, 0);
    checkOutput({tag, ":busy"}, m_busy, 0);
    checkOutput({tag, ":done"}, m_done, 0);
    checkOutput({tag, ":pass"}, m_pass, 0);
    checkOutput({tag, ":gt_count"}, m_gtc, 0);
    checkOutput({tag, ":err_count"}, m_errc, 0);
    checkOutput({tag, ":first_A"}, m_fea, 0);
    checkOutput({tag, ":first_B"}, m_feb, 0);
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0;
    start0 = 1'b0;
    sel0 = 1'b0;
    applyStimulus(4);
    #12;
    checkAllZero("reset1");
    sel0 = 1'b1;
    #1 checkAllZero("reset0");
    sel0 = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // GT_in is random while idle; nothing may move.
    repeat (5) @(posedge clk);
    #1 checkAllZero("idle_hold");

    $display("[TB] ideal comparator, one settle cycle");
    applyStimulus(0);
    runSweep("ideal", 768, 0);
    checkResults("ideal");

    // Results must hold in DONE regardless of GT_in.
    applyStimulus(4);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("hold:done", m_done, 1);
    applyStimulus(0);
    checkResults("hold");

    $display("[TB] stuck comparators");
    applyStimulus(1);
    runSweep("stuck0", 768, 0);
    checkResults("stuck0");
    applyStimulus(2);
    runSweep("stuck1", 768, 0);
    checkResults("stuck1");

    $display("[TB] randomly corrupted comparators");
    for (int k = 0; k < 3; k++) begin
      applyStimulus((k == 2) ? 4 : 3);
      runSweep("random", 768, 0);
      checkResults("random");
    end

    $display("[TB] reset in the middle of a sweep");
    applyStimulus(3);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (299) @(posedge clk);
    #1 rst = 1'b1;
    #1 checkAllZero("midreset");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 checkAllZero("after_reset");
    applyStimulus(0);
    runSweep("post_reset", 768, 0);
    checkResults("post_reset");

    $display("[TB] start pulse while busy");
    applyStimulus(3);
    runSweep("restart", 768, 100);
    checkResults("restart");

    $display("[TB] no settle cycles");
    sel0 = 1'b1;
    applyStimulus(0);
    runSweep("nosettle", 512, 0);
    checkResults("nosettle");
    applyStimulus(4);
    runSweep("nosettle_rand", 512, 0);
    checkResults("nosettle_rand");
    applyStimulus(0);
    runSweep("nosettle_again", 512, 0);
    checkResults("nosettle_again");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
